// File: rtl/seq_mult_pkg.sv
// Shared types and sizing constants for the sequential shift-add multiplier.
package seq_mult_pkg;

  // Controller states: waiting for start, shift-add iterations, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_WIDTH = 8;
  localparam int PROD_WIDTH = 2 * MULT_WIDTH;

endpackage : seq_mult_pkg

// File: rtl/seq_mult.sv
// Sequential unsigned shift-add multiplier with a fixed WIDTH-cycle latency.
// The product register feeds the hex display directly, so it only ever holds
// completed results and changes exactly once per finished multiplication.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// CALC  | one shift-add step per cycle, WIDTH cycles, no early exit
// DONE  | single-cycle done pulse, product already updated
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_t      state;
  mult_state_t      state_next;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplr;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    acc_sum;
  logic             calc_last;

  // Partial product for the current step; acc plus mcand never exceeds PW bits.
  assign acc_sum   = mplr[0] ? (acc + mcand) : acc;
  assign calc_last = (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs; start is only looked at while idle.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (calc_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, shift-add iteration, and result hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= PW'(a);
            mplr  <= b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          acc   <= acc_sum;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
          // Final step's sum goes straight to product so it never shows a partial value.
          if (calc_last) begin
            product <= acc_sum;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : seq_mult

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: cycle-exact status checks plus a
// scoreboard of expected products popped on every done pulse.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done   = 0;
  logic [15:0] sb[$];
  logic [15:0] last_prod;

  seq_mult #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; inputs set afterwards are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected product.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          chk("sb_product", 32'(product), 32'(sb.pop_front()));
        end
      end
    end
  end

  // Full operation from cycle 0; optional start injection during CALC.
  task automatic mult_check(input logic [7:0] av, input logic [7:0] bv, input int inject);
    logic [15:0] e;
    int          done_before;
    e = 16'(av) * 16'(bv);
    done_before = n_done;
    a = av;
    b = bv;
    start = 1'b1;
    sb.push_back(e);
    tick();
    for (int c = 1; c <= 8; c++) begin
      start = (c == inject);
      if (c == inject) begin
        a = 8'h01;
        b = 8'h01;
      end
      chk("calc_busy", 32'(busy), 32'd1);
      chk("calc_done", 32'(done), 32'd0);
      chk("calc_hold", 32'(product), 32'(last_prod));
      tick();
    end
    start = 1'b0;
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_product", 32'(product), 32'(e));
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_product", 32'(product), 32'(e));
    chk("done_count", 32'(n_done - done_before), 32'd1);
    last_prod = e;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    a = 8'h55;
    b = 8'h55;
    last_prod = 16'h0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);

    mult_check(8'h0F, 8'h0F, 0);
    mult_check(8'hFF, 8'hFF, 0);
    mult_check(8'h00, 8'hAB, 0);
    mult_check(8'h12, 8'h34, 4);
    chk("ignored_start_idle", 32'(busy), 32'd0);

    // Abort with reset in cycle 4.
    begin
      int done_before;
      done_before = n_done;
      a = 8'h80;
      b = 8'h02;
      start = 1'b1;
      sb.push_back(16'h0100);
      tick();
      start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        if (c == 4) rst = 1'b1;
        if (c == 5) begin
          rst = 1'b0;
          sb.delete();
          last_prod = 16'h0;
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_done", 32'(done), 32'd0);
          chk("abort_product", 32'(product), 32'd0);
        end
        if (c == 9) chk("abort_no_done", 32'(done), 32'd0);
        tick();
      end
      chk("abort_done_count", 32'(n_done - done_before), 32'd0);
    end
    mult_check(8'h80, 8'h02, 0);

    // Start held high: accepts at cycles 0, 10, 20.
    a = 8'h03;
    b = 8'h05;
    start = 1'b1;
    sb.push_back(16'h000F);
    tick();
    for (int c = 1; c <= 30; c++) begin
      if (c == 10 || c == 20) sb.push_back(16'h000F);
      if (c == 30) start = 1'b0;
      chk("held_done", 32'(done), 32'((c == 9) || (c == 19) || (c == 29)));
      chk("held_busy", 32'(busy), 32'(!((c == 10) || (c == 20) || (c == 30))));
      if (c >= 9) chk("held_product", 32'(product), 32'h000F);
      tick();
    end
    tick();
    tick();
    chk("final_idle", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_seq_mult
